// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter using reverse double-dabble:
// one right shift per clock with per-nibble -3 correction, start/busy/done handshake.
module bcd_to_bin #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic [BIN_W-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [4*DIGITS-1:0]  r_bcd;
    logic [BIN_W-1:0]     r_bin;
    logic [CNT_W-1:0]     r_count;
    logic [BIN_W-1:0]     r_binary;
    logic                 r_error;

    logic [4*DIGITS-1:0]  w_bcd_shifted;
    logic [4*DIGITS-1:0]  w_bcd_fixed;
    logic [BIN_W-1:0]     w_bin_shifted;
    logic [DIGITS-1:0]    w_nib_bad;
    logic                 w_in_bad;
    logic                 w_last;

    // The BCD LSB falls into the binary MSB on every step.
    assign {w_bcd_shifted, w_bin_shifted} = {r_bcd, r_bin} >> 1;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nibble
            assign w_nib_bad[gi] = (bcd_in[4*gi +: 4] > 4'd9);
            // A halved nibble >= 8 carried a 10s-weighted bit from above; -3 restores base 10.
            assign w_bcd_fixed[4*gi +: 4] = (w_bcd_shifted[4*gi +: 4] >= 4'd8)
                                          ? (w_bcd_shifted[4*gi +: 4] - 4'd3)
                                          : w_bcd_shifted[4*gi +: 4];
        end
    endgenerate

    assign w_in_bad = |w_nib_bad;
    assign w_last   = (r_count == CNT_W'(BIN_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = w_in_bad ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bcd    <= '0;
            r_bin    <= '0;
            r_count  <= '0;
            r_binary <= '0;
            r_error  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_bcd   <= bcd_in;
                        r_bin   <= '0;
                        r_count <= '0;
                        r_error <= w_in_bad;
                        if (w_in_bad) begin
                            r_binary <= '0;
                        end
                    end
                end
                S_SHIFT: begin
                    r_bcd   <= w_bcd_fixed;
                    r_bin   <= w_bin_shifted;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_binary <= w_bin_shifted;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign binary = r_binary;
    assign error  = r_error;

endmodule
